activation_lut_loader: RTL and testbench

ACTIVATION_LUT_LOADER -- requirements
Module: activation_lut_loader

---
 rtl/activation_lut_loader_if.sv | 26 ++
 rtl/activation_lut_loader.sv | 68 ++++++
 tb/tb_activation_lut_loader.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/activation_lut_loader_if.sv
// activation_lut_loader_if: control, input stream, LUT write port and status of the LUT loader.
interface activation_lut_loader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic                  abort;
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic                  lut_we;
    logic [ADDR_WIDTH-1:0] lut_addr;
    logic [DATA_WIDTH-1:0] lut_wdata;
    logic                  busy;
    logic                  done;
    logic                  aborted;
    logic [15:0]           checksum;
    modport master (
        output start, abort, s_valid, s_data,
        input  s_ready, lut_we, lut_addr, lut_wdata, busy, done, aborted, checksum
    );
    modport slave (
        input  start, abort, s_valid, s_data,
        output s_ready, lut_we, lut_addr, lut_wdata, busy, done, aborted, checksum
    );
endinterface

// File: rtl/activation_lut_loader.sv
// activation_lut_loader: streams 2^ADDR_WIDTH words into a LUT in ascending address order.
module activation_lut_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    activation_lut_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [15:0]           r_checksum;
    logic                  r_aborted;
    logic                  w_ready;
    logic                  w_hs;
    logic                  w_start;
    always_comb begin
        w_ready = (r_state == LOAD) && !bus.abort;
        w_hs    = bus.s_valid && w_ready;
        w_start = bus.start && !bus.abort && (r_state != LOAD);
        w_next  = r_state;
        if (r_state == LOAD)
            w_next = bus.abort ? IDLE : (w_hs && r_cnt == '1) ? DONE : LOAD;
        else if (w_start)
            w_next = LOAD;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_checksum <= '0;
            r_aborted  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_we    <= w_hs;
            if (w_hs) begin
                r_addr     <= r_cnt;
                r_wdata    <= bus.s_data;
                r_checksum <= r_checksum + 16'(bus.s_data);
                r_cnt      <= r_cnt + 1'b1;
            end
            // start is only honoured outside LOAD, so it never races a handshake update
            if (w_start) begin
                r_cnt      <= '0;
                r_checksum <= '0;
                r_aborted  <= 1'b0;
            end
            if (r_state == LOAD && bus.abort)
                r_aborted <= 1'b1;
        end
    end
    assign bus.s_ready   = w_ready;
    assign bus.lut_we    = r_we;
    assign bus.lut_addr  = r_addr;
    assign bus.lut_wdata = r_wdata;
    assign bus.busy      = (r_state == LOAD);
    assign bus.done      = (r_state == DONE);
    assign bus.aborted   = r_aborted;
    assign bus.checksum  = r_checksum;
endmodule

// File: tb/tb_activation_lut_loader.sv
// tb_activation_lut_loader: directed vector table plus multi-cycle load, gap, abort and reset sequences.
module tb_activation_lut_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    int n_wr = 0;
    int n0;
    activation_lut_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();
    activation_lut_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(negedge clk) if (bus.lut_we) n_wr++;
    typedef struct {
        logic [2:0]  sav;
        logic [7:0]  d;
        logic [4:0]  rbdaw;
        logic [15:0] cs;
    } vec_t;
    vec_t tbl [11];
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic pulse_start;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
    endtask
    task automatic put(input logic [7:0] d, input int k);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        @(negedge clk);
        chk("put_ready", 32'(bus.s_ready), 1);
        tick;
        bus.s_valid = 1'b0;
        chk("put_we", 32'(bus.lut_we), 1);
        chk("put_addr", 32'(bus.lut_addr), k);
        chk("put_wdata", 32'(bus.lut_wdata), 32'(d));
    endtask
    task automatic chk_zero(input string n);
        chk({n, "_ready"}, 32'(bus.s_ready), 0);
        chk({n, "_we"}, 32'(bus.lut_we), 0);
        chk({n, "_addr"}, 32'(bus.lut_addr), 0);
        chk({n, "_wdata"}, 32'(bus.lut_wdata), 0);
        chk({n, "_busy"}, 32'(bus.busy), 0);
        chk({n, "_done"}, 32'(bus.done), 0);
        chk({n, "_aborted"}, 32'(bus.aborted), 0);
        chk({n, "_cs"}, 32'(bus.checksum), 0);
    endtask
    initial begin
        // {start,abort,s_valid}, s_data, {ready during cycle, busy, done, aborted, we after edge}, checksum after edge
        tbl[0]  = '{3'b111, 8'h11, 5'b00000, 16'd0};
        tbl[1]  = '{3'b011, 8'h22, 5'b00000, 16'd0};
        tbl[2]  = '{3'b100, 8'h00, 5'b01000, 16'd0};
        tbl[3]  = '{3'b001, 8'h05, 5'b11001, 16'd5};
        tbl[4]  = '{3'b101, 8'h07, 5'b11001, 16'd12};
        tbl[5]  = '{3'b000, 8'h00, 5'b11000, 16'd12};
        tbl[6]  = '{3'b011, 8'h09, 5'b00010, 16'd12};
        tbl[7]  = '{3'b010, 8'h00, 5'b00010, 16'd12};
        tbl[8]  = '{3'b101, 8'h33, 5'b01000, 16'd0};
        tbl[9]  = '{3'b001, 8'h02, 5'b11001, 16'd2};
        tbl[10] = '{3'b010, 8'h00, 5'b00010, 16'd2};
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        #1;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick;
        chk_zero("post_reset");
        for (int i = 0; i < 11; i++) begin
            {bus.start, bus.abort, bus.s_valid} = tbl[i].sav;
            bus.s_data = tbl[i].d;
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), 32'(bus.s_ready), 32'(tbl[i].rbdaw[4]));
            tick;
            chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(tbl[i].rbdaw[3]));
            chk($sformatf("vec%0d_done", i), 32'(bus.done), 32'(tbl[i].rbdaw[2]));
            chk($sformatf("vec%0d_aborted", i), 32'(bus.aborted), 32'(tbl[i].rbdaw[1]));
            chk($sformatf("vec%0d_we", i), 32'(bus.lut_we), 32'(tbl[i].rbdaw[0]));
            chk($sformatf("vec%0d_cs", i), 32'(bus.checksum), 32'(tbl[i].cs));
        end
        {bus.start, bus.abort, bus.s_valid} = 3'b000;
        tick;
        // full load with an ignored start after 20 words
        pulse_start;
        chk("full_busy", 32'(bus.busy), 1);
        chk("full_aborted_clr", 32'(bus.aborted), 0);
        chk("full_cs_clr", 32'(bus.checksum), 0);
        n0 = n_wr;
        for (int k = 0; k < 256; k++) begin
            if (k == 20) begin
                pulse_start;
                chk("start_in_load_busy", 32'(bus.busy), 1);
                chk("start_in_load_cs", 32'(bus.checksum), 190);
            end
            put(8'(k), k);
        end
        tick;
        chk("full_done", 32'(bus.done), 1);
        chk("full_busy_end", 32'(bus.busy), 0);
        chk("full_ready_end", 32'(bus.s_ready), 0);
        chk("full_cs", 32'(bus.checksum), 32'h7F80);
        chk("full_nwr", n_wr - n0, 256);
        n0 = n_wr;
        bus.s_valid = 1'b1;
        bus.s_data = 8'hAA;
        repeat (3) tick;
        bus.s_valid = 1'b0;
        tick;
        chk("after_done_nwr", n_wr - n0, 0);
        chk("after_done_addr_hold", 32'(bus.lut_addr), 255);
        chk("after_done_wdata_hold", 32'(bus.lut_wdata), 255);
        // reload from DONE with gaps and periodic stalls
        pulse_start;
        chk("reload_done_clr", 32'(bus.done), 0);
        chk("reload_cs_clr", 32'(bus.checksum), 0);
        chk("reload_busy", 32'(bus.busy), 1);
        n0 = n_wr;
        for (int k = 0; k < 256; k++) begin
            put(8'(k), k);
            tick;
            if (k % 32 == 31) repeat (5) tick;
        end
        chk("gap_cs", 32'(bus.checksum), 32'h7F80);
        chk("gap_nwr", n_wr - n0, 256);
        chk("gap_done", 32'(bus.done), 1);
        // abort on the 11th word
        pulse_start;
        n0 = n_wr;
        for (int k = 0; k < 10; k++) put(8'hFF, k);
        bus.s_valid = 1'b1;
        bus.s_data = 8'hFF;
        bus.abort = 1'b1;
        @(negedge clk);
        chk("abort_ready", 32'(bus.s_ready), 0);
        tick;
        bus.abort = 1'b0;
        bus.s_valid = 1'b0;
        chk("abort_we", 32'(bus.lut_we), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_aborted", 32'(bus.aborted), 1);
        chk("abort_done", 32'(bus.done), 0);
        chk("abort_cs", 32'(bus.checksum), 32'h09F6);
        chk("abort_addr_hold", 32'(bus.lut_addr), 9);
        tick;
        chk("abort_nwr", n_wr - n0, 10);
        // asynchronous reset mid-load with a write pending
        pulse_start;
        for (int k = 0; k < 100; k++) put(8'(k), k);
        #2 rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        @(negedge clk) rst_n = 1'b1;
        repeat (2) tick;
        chk("midreset_wait", 32'(bus.busy), 0);
        pulse_start;
        n0 = n_wr;
        for (int k = 0; k < 256; k++) put(8'h01, k);
        tick;
        chk("ones_cs", 32'(bus.checksum), 32'h0100);
        chk("ones_nwr", n_wr - n0, 256);
        chk("ones_done", 32'(bus.done), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
